// File: rtl/disp_sched.sv
// disp_sched: time-shares the six-digit seven-segment display between three
// sources: live guess entry, one-shot feedback frames and status frames.
// Feedback and status frames are latched and held for HOLD_CYCLES clocks.
// A status frame preempts feedback. At most one feedback frame is parked
// while status shows, and the newest parked frame wins.
// Optional build macro DISP_BLINK_EN blinks the status frame
// (BLINK_CYCLES on, BLINK_CYCLES off). The hold time is not affected.
module disp_sched #(
  parameter int HOLD_CYCLES  = 8,
  parameter int CNT_W        = 32,
  parameter int BLINK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] entry_data,
  input  logic        fb_req,
  input  logic [23:0] fb_data,
  input  logic        stat_req,
  input  logic [23:0] stat_data,
  output logic [19:0] num_output,
  output logic [3:0]  times_output,
  output logic [2:0]  gnt,
  output logic        busy
);

  typedef enum logic [1:0] {LIVE, SHOW_FB, SHOW_STAT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [23:0]      fb_buf, fb_n, stat_buf, stat_n, pend_buf, pend_n;
  logic             pend_vld, pend_vld_n;
  logic [23:0]      frame_n;
  logic [2:0]       gnt_n;

  // The display driver decodes only 0-9, so any nibble above 9 becomes 0.
  function automatic logic [23:0] sanitize(input logic [23:0] f);
    logic [23:0] r;
    r = f;
    for (int i = 0; i < 6; i++)
      if (f[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd0;
    return r;
  endfunction

  // Next-state logic. A request always beats an expiry in the same cycle.
  always_comb begin
    st_n       = st;
    cnt_n      = cnt;
    fb_n       = fb_buf;
    stat_n     = stat_buf;
    pend_n     = pend_buf;
    pend_vld_n = pend_vld;
    case (st)
      LIVE: begin
        if (stat_req) begin
          st_n   = SHOW_STAT;
          stat_n = stat_data;
          cnt_n  = '0;
          if (fb_req) begin
            pend_n     = fb_data;
            pend_vld_n = 1'b1;
          end
        end else if (fb_req) begin
          st_n  = SHOW_FB;
          fb_n  = fb_data;
          cnt_n = '0;
        end
      end
      SHOW_FB: begin
        cnt_n = cnt + 1'b1;
        if (stat_req) begin
          // Preempt: park the feedback frame, or the newer one if it arrives now.
          st_n       = SHOW_STAT;
          stat_n     = stat_data;
          cnt_n      = '0;
          pend_n     = fb_req ? fb_data : fb_buf;
          pend_vld_n = 1'b1;
        end else if (fb_req) begin
          fb_n  = fb_data;
          cnt_n = '0;
        end else if (cnt == LAST) begin
          st_n  = LIVE;
          cnt_n = cnt;
        end
      end
      SHOW_STAT: begin
        cnt_n = cnt + 1'b1;
        if (stat_req) begin
          stat_n = stat_data;
          cnt_n  = '0;
          if (fb_req) begin
            pend_n     = fb_data;
            pend_vld_n = 1'b1;
          end
        end else if (cnt == LAST) begin
          // Expiry. A feedback frame arriving now is newer than any parked one.
          if (fb_req || pend_vld) begin
            st_n       = SHOW_FB;
            fb_n       = fb_req ? fb_data : pend_buf;
            cnt_n      = '0;
            pend_vld_n = 1'b0;
          end else begin
            st_n  = LIVE;
            cnt_n = cnt;
          end
        end else if (fb_req) begin
          pend_n     = fb_data;
          pend_vld_n = 1'b1;
        end
      end
      default: st_n = LIVE;
    endcase
  end

`ifdef DISP_BLINK_EN
  localparam logic [CNT_W-1:0] BLAST = CNT_W'(BLINK_CYCLES - 1);
  logic             phase, phase_n;
  logic [CNT_W-1:0] bcnt, bcnt_n;

  // Blink phase. It restarts in the on phase at each status entry or restart.
  always_comb begin
    phase_n = phase;
    bcnt_n  = bcnt;
    if (st_n == SHOW_STAT && (st != SHOW_STAT || stat_req)) begin
      phase_n = 1'b1;
      bcnt_n  = '0;
    end else if (st == SHOW_STAT) begin
      if (bcnt == BLAST) begin
        phase_n = ~phase;
        bcnt_n  = '0;
      end else begin
        bcnt_n = bcnt + 1'b1;
      end
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 1'b1;
      bcnt  <= '0;
    end else begin
      phase <= phase_n;
      bcnt  <= bcnt_n;
    end
  end
`endif

  // Select the frame and the one-hot grant for the source displayed next cycle.
  always_comb begin
    frame_n = entry_data;
    gnt_n   = 3'b001;
    case (st_n)
      SHOW_FB:   begin frame_n = fb_n;   gnt_n = 3'b010; end
      SHOW_STAT: begin
`ifdef DISP_BLINK_EN
        frame_n = phase_n ? stat_n : 24'h0;
`else
        frame_n = stat_n;
`endif
        gnt_n = 3'b100;
      end
      default: ;
    endcase
  end

  // Control and frame-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= LIVE;
      cnt      <= '0;
      fb_buf   <= '0;
      stat_buf <= '0;
      pend_buf <= '0;
      pend_vld <= 1'b0;
    end else begin
      st       <= st_n;
      cnt      <= cnt_n;
      fb_buf   <= fb_n;
      stat_buf <= stat_n;
      pend_buf <= pend_n;
      pend_vld <= pend_vld_n;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_output   <= '0;
      times_output <= '0;
      gnt          <= 3'b001;
      busy         <= 1'b0;
    end else begin
      {times_output, num_output} <= sanitize(frame_n);
      gnt                        <= gnt_n;
      busy                       <= gnt_n[1] | gnt_n[2];
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched. Each step drives one cycle of stimulus and
// queues the expected display. The entry is popped and compared after the edge.
module tb_disp_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] entry_data = '0, fb_data = '0, stat_data = '0;
  logic        fb_req = 1'b0, stat_req = 1'b0;
  logic [19:0] num_output;
  logic [3:0]  times_output;
  logic [2:0]  gnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [23:0] E   = 24'h3_12345;
  localparam logic [23:0] FB1 = 24'h1_22222;
  localparam logic [23:0] ST1 = 24'h9_55555;
  localparam logic [23:0] FB2 = 24'h2_77777;

  typedef struct packed {
    logic [23:0] frame;
    logic [2:0]  gnt;
  } exp_t;
  exp_t sb[$];

  disp_sched dut (
    .clk(clk), .rst(rst), .entry_data(entry_data),
    .fb_req(fb_req), .fb_data(fb_data),
    .stat_req(stat_req), .stat_data(stat_data),
    .num_output(num_output), .times_output(times_output),
    .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected status frame k cycles after the last status entry or restart.
  function automatic logic [23:0] sf(input logic [23:0] f, input int k);
`ifdef DISP_BLINK_EN
    return ((k / 4) % 2) ? 24'h0 : f;
`else
    return f;
`endif
  endfunction

  task automatic step(input string tag, input logic [23:0] e, input logic fr,
                      input logic [23:0] fd, input logic sr, input logic [23:0] sd,
                      input logic [23:0] ef, input logic [2:0] eg);
    exp_t x;
    @(negedge clk);
    entry_data = e; fb_req = fr; fb_data = fd; stat_req = sr; stat_data = sd;
    sb.push_back('{frame: ef, gnt: eg});
    @(posedge clk);
    #1;
    fb_req = 1'b0; stat_req = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk({tag, "_dig"}, {8'h0, times_output, num_output}, {8'h0, x.frame});
      chk({tag, "_gnt"}, {29'h0, gnt}, {29'h0, x.gnt});
      chk({tag, "_busy"}, {31'h0, busy}, {31'h0, (x.gnt != 3'b001)});
    end
  endtask

  task automatic idle(input string tag, input logic [23:0] ef, input logic [2:0] eg);
    step(tag, E, 1'b0, 24'h0, 1'b0, 24'h0, ef, eg);
  endtask

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dig", {8'h0, times_output, num_output}, 32'h0);
    chk("rst_gnt", {29'h0, gnt}, 32'd1);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Live entry, including nibble sanitising.
    idle("live", E, 3'b001);
    step("sanit", 24'h4_9A111, 1'b0, 0, 1'b0, 0, 24'h4_90111, 3'b001);

    // Feedback holds for 8 cycles, then the display returns to the entry.
    step("fb0", E, 1'b1, FB1, 1'b0, 0, FB1, 3'b010);
    for (int i = 1; i < 8; i++) idle("fb", FB1, 3'b010);
    idle("fb_end", E, 3'b001);

    // Status preempts at counter 3, then the parked feedback shows for a full hold.
    step("pre_fb", E, 1'b1, FB1, 1'b0, 0, FB1, 3'b010);
    for (int i = 1; i < 4; i++) idle("pre_fb", FB1, 3'b010);
    step("pre_st", E, 1'b0, 0, 1'b1, ST1, sf(ST1, 0), 3'b100);
    for (int k = 1; k < 8; k++) idle("pre_st", sf(ST1, k), 3'b100);
    for (int i = 0; i < 8; i++) idle("pre_pend", FB1, 3'b010);
    idle("pre_end", E, 3'b001);

    // Simultaneous requests. A later feedback replaces the parked one.
    step("both", E, 1'b1, FB1, 1'b1, ST1, sf(ST1, 0), 3'b100);
    for (int k = 1; k < 3; k++) idle("both_st", sf(ST1, k), 3'b100);
    step("repl", E, 1'b1, FB2, 1'b0, 0, sf(ST1, 3), 3'b100);
    for (int k = 4; k < 8; k++) idle("both_st", sf(ST1, k), 3'b100);
    for (int i = 0; i < 8; i++) idle("both_fb", FB2, 3'b010);
    idle("both_end", E, 3'b001);

    // Status is restarted every 5 cycles and never expires.
    for (int r = 0; r < 4; r++) begin
      step("rep_st", E, 1'b0, 0, 1'b1, ST1, sf(ST1, 0), 3'b100);
      for (int k = 1; k < 5; k++) idle("rep_st", sf(ST1, k), 3'b100);
    end
    step("rep_park", E, 1'b1, FB2, 1'b0, 0, sf(ST1, 5), 3'b100);
    // Reset mid-hold clears the outputs immediately.
    @(negedge clk) rst = 1'b1;
    #1;
    chk("arst_dig", {8'h0, times_output, num_output}, 32'h0);
    chk("arst_gnt", {29'h0, gnt}, 32'd1);
    chk("arst_busy", {31'h0, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    idle("post_rst", E, 3'b001);
    // The parked frame was discarded, so a status expiry returns to LIVE.
    step("post_st", E, 1'b0, 0, 1'b1, ST1, sf(ST1, 0), 3'b100);
    for (int k = 1; k < 8; k++) idle("post_st", sf(ST1, k), 3'b100);
    idle("no_pend", E, 3'b001);

    // Status blink pattern, or a steady frame in the default build.
    step("blink", E, 1'b0, 0, 1'b1, 24'h5_12121, sf(24'h5_12121, 0), 3'b100);
    for (int k = 1; k < 8; k++) idle("blink", sf(24'h5_12121, k), 3'b100);
    idle("blink_end", E, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Time-shares the six-digit seven-segment display between three sources: live guess entry, per-guess feedback, and a game status message.
- Latches one-shot feedback and status frames and holds each on screen for a fixed time, then falls back to the live entry digits.
- Sits between the game controller and the seven-segment driver. It drives the driver's num_output (5 digits) and times_output (attempt digit) buses.

Parameters:
- HOLD_CYCLES, 8, clk cycles a latched feedback/status frame stays displayed (synthesis builds override, e.g. 50_000_000); minimum 2.
- CNT_W, 32, width of the hold counter; must hold HOLD_CYCLES-1.
- BLINK_CYCLES, 4, half-period of the status blink (DISP_BLINK_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- entry_data  in  24  live digits: [19:0] five guess digits, [23:20] attempt count
- fb_req  in  1  one-cycle pulse: capture fb_data and show it
- fb_data  in  24  feedback frame, same packing as entry_data
- stat_req  in  1  one-cycle pulse: capture stat_data and show it
- stat_data  in  24  status frame, same packing
- num_output  out  20  five digits to display driver
- times_output  out  4  sixth digit to display driver
- gnt  out  3  one-hot current source: [0] entry, [1] feedback, [2] status
- busy  out  1  high while a latched frame is showing (state != LIVE)

Behaviour:
- Reset (async, rst=1): state LIVE, num_output=0, times_output=0, gnt=3'b001, busy=0, counter=0, pending flag clear, frame buffers cleared.
- States: LIVE, SHOW_FB, SHOW_STAT.
- All outputs registered. A decision made from inputs at edge N appears at outputs after edge N (one-cycle latency).
- LIVE:
  - Outputs track entry_data every cycle.
  - stat_req -> capture stat_data, go to SHOW_STAT, counter=0.
  - Else fb_req -> capture fb_data, go to SHOW_FB, counter=0.
  - Both in the same cycle -> SHOW_STAT wins; the fb frame is captured into the pending buffer and the pending flag is set.
- SHOW_FB:
  - Counter increments each cycle. At counter==HOLD_CYCLES-1 -> LIVE.
  - fb_req -> recapture fb_data, counter=0 (restart).
  - stat_req -> preempt: current fb frame moves to pending, go to SHOW_STAT, counter=0.
  - Both in the same cycle -> new fb_data goes to pending, then stat is shown.
- SHOW_STAT:
  - Counter increments each cycle.
  - stat_req -> recapture stat_data, counter=0.
  - fb_req -> overwrite the pending buffer and set the pending flag (one-deep; newest wins).
  - At expiry: pending set -> SHOW_FB with the pending frame, counter=0, pending cleared; else -> LIVE.
  - A request arriving in the expiry cycle takes precedence over expiry and follows the rules above.
- Digit sanitising: any output nibble >9 is forced to 0, because the driver decodes only 0-9.
- gnt matches the displayed source every cycle. busy = gnt[1] | gnt[2].
- Counter never wraps; it is only reset on entry or restart.
- Reset mid-hold aborts immediately to LIVE; the pending frame is discarded.

Optional Feature:
- Macro DISP_BLINK_EN.
- Defined: while in SHOW_STAT, a blink counter toggles a phase bit every BLINK_CYCLES cycles. In the off phase num_output=0 and times_output=0; in the on phase stat_data is shown. Phase resets to on at every SHOW_STAT entry or restart. The hold time itself is unchanged.
- Undefined: the status frame is shown steadily. No blink counter or phase logic is synthesised.

Test Plan:
- Reset, then entry_data=24'h3_12345 -> after 1 clk num_output=20'h12345, times_output=3, gnt=001, busy=0. Apply entry_data=24'h4_9A111 -> num_output=20'h90111 (A sanitised to 0).
- fb_req pulse with fb_data=24'h1_22222 -> num_output=20'h22222, gnt=010, busy=1 for exactly 8 cycles, then entry digits and gnt=001.
- During SHOW_FB at counter 3, stat_req with stat_data=24'h9_55555 -> 55555/9 shown for 8 cycles, then 22222/1 shown for a fresh 8 cycles, then LIVE.
- fb_req and stat_req in the same cycle from LIVE -> status shown 8 cycles, then feedback 8 cycles. A second fb_req during status with 24'h2_77777 -> pending replaced, 77777 shown after status.
- Repeated stat_req every 5 cycles -> stays in SHOW_STAT (never expires); assert rst mid-hold -> outputs 0, gnt=001 immediately, no pending frame after reset release.
- With DISP_BLINK_EN: stat frame 24'h5_12121 -> outputs alternate 12121/5 and 00000/0 every 4 cycles, starting on, for 8 cycles total.
